xbar_port_dispatcher: RTL and testbench
=======================================

Name: xbar_port_dispatcher

Overview:
- Consumer side of the tagged-word interface driven by the upstream classification stage (write strobe, 32-bit control word, 480-bit data word).
- Decodes the crossbar egress index carried in the control word and steers each valid word into one of NUM_PORTS per-egress FIFOs.
- Each egress presents a first-word-fall-through valid/ready interface to its downstream queue.
- Upstream has no backpressure, so words arriving for a full FIFO or an out-of-range index are dropped and counted.

Parameters:
DATA_WIDTH, 480, data word width
CTRL_WIDTH, 32, control word width
NUM_PORTS, 4, egress count; legal values 2..16
FIFO_DEPTH, 4, words per egress FIFO; power of 2, at least 2
PTR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_wr  in  1  input word valid, one word per asserted cycle
in_ctl  in  CTRL_WIDTH  control word; [3:0] egress index, [27:4] src/dst/pcie tags passed through untouched
in_data  in  DATA_WIDTH  data word
out_valid  out  NUM_PORTS  bit p: egress p FIFO head is valid
out_ctl  out  NUM_PORTS*CTRL_WIDTH  slice p: head control word of egress p
out_data  out  NUM_PORTS*DATA_WIDTH  slice p: head data word of egress p
out_rdy  in  NUM_PORTS  bit p: downstream p accepts head this cycle
port_full  out  NUM_PORTS  bit p: egress p FIFO holds FIFO_DEPTH words
drop_cnt  out  16  saturating count of dropped words

Behaviour:
- Reset (rst low, asynchronous): all pointers and occupancy counts go to 0. out_valid=0, port_full=0, drop_cnt=0. out_ctl and out_data go to 0. FIFO storage is not cleared.
- Reset asserted mid-operation discards all queued words. No output handshake completes in the reset cycle.
- Decode: idx = in_ctl[3:0]. A word is accepted when in_wr=1, idx<NUM_PORTS and occupancy[idx]<FIFO_DEPTH, with occupancy sampled at the start of the cycle.
- Accepted words store {in_ctl, in_data} unmodified at the write pointer of FIFO idx.
- Drop conditions: in_wr=1 and idx>=NUM_PORTS, or in_wr=1 and FIFO idx full. On a drop, drop_cnt increments by 1 and saturates at 16'hFFFF. Nothing is stored.
- Full FIFO with a simultaneous pop: the incoming word is still dropped. The full check does not account for a same-cycle pop.
- Pop: egress p pops when out_valid[p]=1 and out_rdy[p]=1. The read pointer advances.
- out_rdy[p] with out_valid[p]=0 has no effect.
- Occupancy per egress changes by +1 on accept only, -1 on pop only, and 0 on accept plus pop in the same cycle.
- Latency: a word accepted at edge N is visible on out_valid/out_ctl/out_data at the output of edge N, i.e. usable in cycle N+1. One-cycle write-to-read latency, including into an empty FIFO.
- out_valid[p] = (occupancy[p] != 0). port_full[p] = (occupancy[p] == FIFO_DEPTH). Both are registered.
- Head data: out_ctl/out_data slice p is driven from storage at the read pointer. When out_valid[p]=0 the slice is don't-care and the bench must not check it.
- Pointers are PTR_WIDTH bits and wrap modulo FIFO_DEPTH. Occupancy is PTR_WIDTH+1 bits.
- Ordering: FIFO order is preserved per egress. There is no ordering guarantee across egresses.
- All egresses pop independently and concurrently. Exactly one FIFO can be written per cycle.
- in_ctl[CTRL_WIDTH-1:4] does not influence routing.

Test Plan:
- Reset then idle: out_valid=0, port_full=0, drop_cnt=0. Stays so for 10 cycles with in_wr=0.
- Single word: in_wr=1, in_ctl=32'h0123_4562, in_data=480'hA5. Next cycle out_valid=4'b0100, slice 2 ctl=32'h01234562, data=480'hA5. Pop with out_rdy[2]=1, then out_valid=0.
- Fill: 5 words to egress 1 with out_rdy=0. First 4 stored, port_full[1]=1, drop_cnt=1. Drain with out_rdy[1]=1 returns words in order 0..3.
- Out-of-range: in_ctl[3:0]=4'h7 with NUM_PORTS=4. drop_cnt increments, out_valid unchanged.
- Full with simultaneous pop: egress 0 full, write to 0 while out_rdy[0]=1. Word dropped, occupancy becomes 3, drop_cnt+1.
- Streaming and wrap: alternate writes to egresses 0 and 3 for 20 cycles with out_rdy=4'b1111. No drops, all 20 words delivered in per-egress order, pointers wrap. Then assert reset mid-stream: out_valid=0 immediately, drop_cnt=0.

Source files
------------

// File: rtl/xbar_port_dispatcher.sv
// Steers tagged words from the classification stage into per-egress FWFT FIFOs.
// Words for a full FIFO or a nonexistent egress are dropped and counted.

module xbar_egress_fifo #(
  parameter int CTRL_WIDTH = 32,
  parameter int DATA_WIDTH = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             rdy,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] wr_word,
  output logic                             valid,
  output logic                             full,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] head
);
  localparam int WW = CTRL_WIDTH + DATA_WIDTH;
  localparam int CW = PTR_WIDTH + 1;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 pop;

  assign pop = valid & rdy;

  always_comb begin
    rd_nxt  = pop ? rd_ptr + PTR_WIDTH'(1) : rd_ptr;
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!push && pop) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_word;

  // Head is registered; a word written where the next read pointer lands
  // bypasses storage so an empty FIFO still shows it one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      valid  <= (cnt_nxt != '0);
      full   <= (cnt_nxt == CW'(FIFO_DEPTH));
      head   <= (push && wr_ptr == rd_nxt) ? wr_word : mem[rd_nxt];
    end
  end
endmodule

module xbar_port_dispatcher #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_wr,
  input  logic [CTRL_WIDTH-1:0]           in_ctl,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  output logic [NUM_PORTS*CTRL_WIDTH-1:0] out_ctl,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_PORTS-1:0]            out_rdy,
  output logic [NUM_PORTS-1:0]            port_full,
  output logic [15:0]                     drop_cnt
);
  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctl;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [3:0]           idx;
  logic [NUM_PORTS-1:0] push;
  word_t                wr_word;
  word_t [NUM_PORTS-1:0] head;

  assign idx     = in_ctl[3:0];
  assign wr_word = '{ctl: in_ctl, data: in_data};

  // An index >= NUM_PORTS matches no egress, so it falls out as a drop.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign push[p] = in_wr && (idx == 4'(p)) && !port_full[p];

    xbar_egress_fifo #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[p]),
      .rdy     (out_rdy[p]),
      .wr_word (wr_word),
      .valid   (out_valid[p]),
      .full    (port_full[p]),
      .head    (head[p])
    );

    assign out_ctl[p*CTRL_WIDTH +: CTRL_WIDTH]  = head[p].ctl;
    assign out_data[p*DATA_WIDTH +: DATA_WIDTH] = head[p].data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (in_wr && !(|push) && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
endmodule

// File: tb/tb_xbar_port_dispatcher.sv
// Directed and random stimulus for xbar_port_dispatcher against a queue-based reference.
module tb_xbar_port_dispatcher;
  localparam int NP = 4;
  localparam int DW = 480;
  localparam int CW = 32;
  localparam int D  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_wr;
  logic [CW-1:0]      in_ctl;
  logic [DW-1:0]      in_data;
  logic [NP-1:0]      out_valid, out_rdy, port_full;
  logic [NP*CW-1:0]   out_ctl;
  logic [NP*DW-1:0]   out_data;
  logic [15:0]        drop_cnt;

  always #5 clk = ~clk;

  xbar_port_dispatcher dut (
    .clk       (clk),
    .rst       (rst),
    .in_wr     (in_wr),
    .in_ctl    (in_ctl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ctl   (out_ctl),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .port_full (port_full),
    .drop_cnt  (drop_cnt)
  );

  // Reference: one queue of {ctl,data} per egress plus a drop tally.
  logic [CW+DW-1:0] mq [NP][$];
  int m_drop;
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) mq[p].delete();
    m_drop = 0;
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NP; p++) begin
      check($sformatf("valid%0d", p), out_valid[p], mq[p].size() != 0);
      check($sformatf("full%0d", p), port_full[p], mq[p].size() == D);
      if (mq[p].size() != 0)
        check($sformatf("head%0d", p), {out_ctl[p*CW +: CW], out_data[p*DW +: DW]}, mq[p][0]);
    end
    check("drop_cnt", drop_cnt, (m_drop > 65535) ? 65535 : m_drop);
  endtask

  task automatic cycle(input bit wr, input logic [CW-1:0] ctl, input logic [DW-1:0] data,
                       input logic [NP-1:0] rdy);
    int  idx;
    bit  acc;
    in_wr = wr; in_ctl = ctl; in_data = data; out_rdy = rdy;
    @(posedge clk);
    idx = int'(ctl[3:0]);
    acc = 1'b0;
    if (wr && idx < NP) acc = (mq[idx].size() < D);
    for (int p = 0; p < NP; p++)
      if (mq[p].size() != 0 && rdy[p]) void'(mq[p].pop_front());
    if (acc) mq[idx].push_back({ctl, data});
    else if (wr) m_drop++;
    #1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] prev_valid;
    logic [CW-1:0] c;
    rst = 1'b1; in_wr = 1'b0; in_ctl = '0; in_data = '0; out_rdy = '0;
    model_reset();
    #3 rst = 1'b0;
    #4;
    check("rst_valid", out_valid, 0);
    check("rst_full", port_full, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ctl", out_ctl, 0);
    check("rst_data", |out_data, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 10; i++) cycle(0, '0, '0, '0);

    // single word to egress 2
    cycle(1, 32'h0123_4562, 480'hA5, 4'b0000);
    check("single_valid", out_valid, 4'b0100);
    check("single_ctl", out_ctl[2*CW +: CW], 32'h0123_4562);
    check("single_data", out_data[2*DW +: DW], 480'hA5);
    cycle(0, '0, '0, 4'b0100);
    check("single_popped", out_valid, 4'b0000);

    // fill egress 1 with five words, fifth one dropped
    for (int i = 0; i < 5; i++) cycle(1, {24'(i), 8'h01}, DW'(i), 4'b0000);
    check("fill_full", port_full[1], 1);
    check("fill_drop", drop_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_data[1*DW +: DW], DW'(i));
      cycle(0, '0, '0, 4'b0010);
    end
    check("drain_empty", out_valid[1], 0);

    // out-of-range index
    prev_valid = out_valid;
    cycle(1, 32'hDEAD_BEE7, rnd_data(), 4'b0000);
    check("oor_drop", drop_cnt, 2);
    check("oor_valid", out_valid, prev_valid);

    // full egress 0 with a same-cycle pop still drops the incoming word
    for (int i = 0; i < 4; i++) cycle(1, {24'(i + 16), 8'h00}, rnd_data(), 4'b0000);
    check("f0_full", port_full[0], 1);
    cycle(1, 32'hFFFF_FF00, rnd_data(), 4'b0001);
    check("fpop_drop", drop_cnt, 3);
    check("fpop_notfull", port_full[0], 0);
    check("fpop_valid", out_valid[0], 1);
    cycle(0, '0, '0, 4'b0001);
    cycle(0, '0, '0, 4'b0001);
    check("fpop_two_left", out_valid[0], 1);
    cycle(0, '0, '0, 4'b0001);
    check("fpop_three_only", out_valid[0], 0);

    // streaming with wrap: alternate egress 0 and 3, all ready
    for (int i = 0; i < 20; i++) begin
      c = $urandom;
      c[3:0] = (i % 2 == 0) ? 4'h0 : 4'h3;
      cycle(1, c, rnd_data(), 4'b1111);
    end
    check("stream_nodrop", drop_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      c = $urandom;
      c[3:0] = (i % 2 == 0) ? 4'h0 : 4'h3;
      cycle(1, c, rnd_data(), 4'b0000);
    end

    // asynchronous reset mid-stream
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_full", port_full, 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    cycle(0, '0, '0, '0);

    // random traffic, some out-of-range indices, sparse ready
    for (int i = 0; i < 400; i++) begin
      logic [NP-1:0] r;
      c = $urandom;
      c[3:0] = 4'($urandom_range(0, 5));
      for (int p = 0; p < NP; p++) r[p] = ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 3) != 0, c, rnd_data(), r);
    end
    for (int i = 0; i < 6; i++) cycle(0, '0, '0, 4'b1111);
    check("final_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
